bti_arb: RTL and testbench
==========================

BTI_ARB -- requirements
Module: bti_arb

Interface
REQ-001 SHALL have parameter BTI_AW, default 32, BTI request address width.
REQ-002 SHALL have parameter BTI_DW, default 32, BTI data width.
REQ-003 SHALL have parameter OST_NUM, default 2, maximum accepted-but-unanswered transactions (power of two, at least 1).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port h0_bti_req_slv, bti_req_if_t slave, BTI_AW/BTI_DW, host 0 request (higher initial priority).
REQ-007 SHALL have port h0_bti_rsp_mst, bti_rsp_if_t master, BTI_DW, host 0 response.
REQ-008 SHALL have port h1_bti_req_slv, bti_req_if_t slave, BTI_AW/BTI_DW, host 1 request.
REQ-009 SHALL have port h1_bti_rsp_mst, bti_rsp_if_t master, BTI_DW, host 1 response.
REQ-010 SHALL have port gst_bti_req_mst, bti_req_if_t master, BTI_AW/BTI_DW, shared guest request.
REQ-011 SHALL have port gst_bti_rsp_slv, bti_rsp_if_t slave, BTI_DW, shared guest response.
REQ-012 SHALL have port err, output, 1, sticky flag set by an orphan guest response.
REQ-013 SHALL treat a BTI request as vld/rdy/cmd/addr/wdata and a BTI response as vld/rdy/rdata/ok, each transferring on the cycle vld and rdy are both high.

Function
REQ-014 SHALL arbitrate round-robin between h0 and h1: on a conflict, grant the host that did not win the last accepted request.
REQ-015 SHALL lock the grant while the granted host holds vld without a handshake, with no switch before acceptance.
REQ-016 SHALL forward the granted host's cmd, addr and wdata to the guest combinationally (0-cycle request latency).
REQ-017 SHALL drive host rdy = guest rdy AND granted AND tracking FIFO not full; the ungranted host's rdy SHALL be 0.
REQ-018 SHALL push the winning host ID into an OST_NUM-deep tracking FIFO on each accepted guest request.
REQ-019 SHALL route each guest response combinationally to the host at the FIFO head (rdata, ok, vld) and return that host's rdy as guest rsp_rdy.
REQ-020 SHALL pop the FIFO on each guest response handshake.
REQ-021 SHALL, with the FIFO full, block all requests even when a pop occurs in the same cycle (no rsp-to-req combinational path).
REQ-022 SHALL, with the FIFO empty, allow push and pop in one cycle only if the response is not the same transaction (the guest response is registered).
REQ-023 SHALL, on a guest rsp vld while the FIFO is empty, drive guest rsp_rdy=1, drop the response, assert no host rsp vld and set err.
REQ-024 SHALL update the round-robin pointer only on an accepted request; idle cycles leave it unchanged.
REQ-025 SHALL, with a single requester, grant it in the same cycle with no penalty.

Reset
REQ-026 SHALL, during rst_n=0, drive rr pointer=host0, grant lock=0, FIFO empty, err=0.
REQ-027 SHALL, during rst_n=0, drive every host rdy, host rsp vld and guest req vld to 0.
REQ-028 SHALL treat a reset mid-transaction as discarding all outstanding IDs; responses arriving afterwards follow REQ-023.

Structure
REQ-029 SHALL place the BTI cmd enum (READ=0, WRITE=1) and the host-ID type in the shared bti_pkg.
REQ-030 SHALL implement the tracking FIFO as sub-module bti_ost_fifo (width 1, depth OST_NUM, push/pop/full/empty/head).
REQ-031 SHALL keep arbitration and the lock register in bti_arb itself.

Verification
REQ-032 SHALL cover: h0 and h1 assert a READ together from reset, guest always ready -> h0 granted cycle 0, h1 cycle 1, then alternating.
REQ-033 SHALL cover: h1 WRITE addr 0x1000_0004 with guest rdy=0 for 3 cycles while h0 asserts -> h1 held until accepted, h0 granted next.
REQ-034 SHALL cover: OST_NUM=2, guest withholds responses -> third request sees rdy=0 until the first response pops.
REQ-035 SHALL cover: responses 0xDEADBEEF then 0x12345678 for accepted order h0,h1 -> h0 gets 0xDEADBEEF, h1 gets 0x12345678.
REQ-036 SHALL cover: guest rsp vld with no outstanding request -> rsp_rdy=1, no host rsp vld, err=1 until reset.
REQ-037 SHALL cover: rst_n low for 1 cycle with 2 transactions outstanding -> FIFO empty, outputs 0; late responses set err.

Source files
------------

// File: rtl/bti_pkg.sv
// ---------------------------------------------------------------------------
// bti_pkg
// Shared definitions for the BTI arbiter slice: the bus command encoding,
// the host-ID type carried in the outstanding-transaction FIFO, the arbiter
// grant-lock states and a small helper that names the opposite host.
// ---------------------------------------------------------------------------
package bti_pkg;

  typedef enum logic {
    BTI_READ  = 1'b0,
    BTI_WRITE = 1'b1
  } bti_cmd_e;

  typedef logic bti_host_id_t;

  localparam bti_host_id_t HOST0 = 1'b0;
  localparam bti_host_id_t HOST1 = 1'b1;

  // ARB_OPEN: free to arbitrate; ARB_LOCK_Hx: host x was shown to the guest
  // without being accepted, so it keeps the grant until its handshake.
  typedef enum logic [1:0] {
    ARB_OPEN    = 2'd0,
    ARB_LOCK_H0 = 2'd1,
    ARB_LOCK_H1 = 2'd2
  } arb_state_e;

  function automatic bti_host_id_t otherHost(input bti_host_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/bti_arb_if.sv
// ---------------------------------------------------------------------------
// bti_req_if_t / bti_rsp_if_t
// BTI request and response channels. Each transfers on a cycle where vld and
// rdy are both high.
//   request : vld, cmd, addr, wdata (master -> slave), rdy (slave -> master)
//   response: vld, rdata, ok        (master -> slave), rdy (slave -> master)
// ---------------------------------------------------------------------------
interface bti_req_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import bti_pkg::*;

  logic          vld;
  logic          rdy;
  bti_cmd_e      cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  modport master (output vld, cmd, addr, wdata, input rdy);
  modport slave  (input vld, cmd, addr, wdata, output rdy);
endinterface

interface bti_rsp_if_t #(
  parameter int DW = 32
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] rdata;
  logic          ok;

  modport master (output vld, rdata, ok, input rdy);
  modport slave  (input vld, rdata, ok, output rdy);
endinterface

// File: rtl/bti_ost_fifo.sv
// ---------------------------------------------------------------------------
// bti_ost_fifo
// Tracks which host owns each accepted-but-unanswered guest transaction, in
// acceptance order, so responses can be routed back.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : append data_i (ignored while full)
//   pop_i      : drop the head entry (ignored while empty)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   head_o     : host ID of the oldest outstanding transaction
// ---------------------------------------------------------------------------
module bti_ost_fifo
  import bti_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  bti_host_id_t data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output bti_host_id_t head_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  bti_host_id_t    mem_q [DEPTH];
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            doPush;
  logic            doPop;

  // Pointers wrap explicitly so any power-of-two depth (including 1) works.
  function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;

  // Advance pointers and occupancy; a simultaneous push and pop keeps the
  // count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = nextPtr(wrPtr_q);
    if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy state; reset discards every tracked ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/bti_arb.sv
// ---------------------------------------------------------------------------
// bti_arb
// Two-host to one-guest BTI arbiter with round-robin grant, grant lock while
// a request waits for acceptance, and in-order response routing through an
// outstanding-ID FIFO.
//   clk, rst_n      : clock, synchronous active-low reset
//   h0_bti_req_slv  : host 0 request (preferred first after reset)
//   h0_bti_rsp_mst  : host 0 response
//   h1_bti_req_slv  : host 1 request
//   h1_bti_rsp_mst  : host 1 response
//   gst_bti_req_mst : shared guest request (0-cycle forward of the winner)
//   gst_bti_rsp_slv : shared guest response
//   err             : sticky; set by a guest response with nothing outstanding
// ---------------------------------------------------------------------------
module bti_arb
  import bti_pkg::*;
#(
  parameter int BTI_AW  = 32,
  parameter int BTI_DW  = 32,
  parameter int OST_NUM = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  bti_req_if_t.slave  h0_bti_req_slv,
  bti_rsp_if_t.master h0_bti_rsp_mst,
  bti_req_if_t.slave  h1_bti_req_slv,
  bti_rsp_if_t.master h1_bti_rsp_mst,
  bti_req_if_t.master gst_bti_req_mst,
  bti_rsp_if_t.slave  gst_bti_rsp_slv,
  output logic        err
);

  arb_state_e          state_q, state_d;
  bti_host_id_t        rrPtr_q, rrPtr_d;
  logic                errFlag_q, errFlag_d;

  logic                h0Vld;
  logic                h1Vld;
  logic                grantValid;
  bti_host_id_t        grantHost;
  logic                gstVld;
  logic                reqAccept;
  logic [BTI_AW-1:0]   selAddr;
  logic [BTI_DW-1:0]   selWdata;

  logic                fifoFull;
  logic                fifoEmpty;
  bti_host_id_t        headHost;
  logic                trackEmpty;
  logic                gstRspRdy;
  logic                rspFire;
  logic                orphan;

  // Requests are invisible while reset is asserted, which forces every
  // handshake output low without depending on register state.
  assign h0Vld = rst_n & h0_bti_req_slv.vld;
  assign h1Vld = rst_n & h1_bti_req_slv.vld;

  // Grant lock, round-robin pointer and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_OPEN;
      rrPtr_q   <= HOST0;
      errFlag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      errFlag_q <= errFlag_d;
    end
  end

  // An accepted request reopens arbitration and hands priority to the other
  // host; a shown-but-unaccepted request locks the grant to its host.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    errFlag_d = errFlag_q | orphan;
    if (reqAccept) begin
      state_d = ARB_OPEN;
      rrPtr_d = otherHost(grantHost);
    end else if (grantValid) begin
      state_d = (grantHost == HOST1) ? ARB_LOCK_H1 : ARB_LOCK_H0;
    end else begin
      state_d = ARB_OPEN;
    end
  end

  // Grant selection: the locked host if any, otherwise the pointer on a
  // conflict, otherwise whichever single host requests. grantValid is only
  // high when the selected host actually has vld asserted.
  always_comb begin
    grantValid = 1'b0;
    grantHost  = rrPtr_q;
    case (state_q)
      ARB_LOCK_H0: begin
        grantValid = h0Vld;
        grantHost  = HOST0;
      end
      ARB_LOCK_H1: begin
        grantValid = h1Vld;
        grantHost  = HOST1;
      end
      default: begin
        if (h0Vld && h1Vld) begin
          grantValid = 1'b1;
          grantHost  = rrPtr_q;
        end else if (h0Vld) begin
          grantValid = 1'b1;
          grantHost  = HOST0;
        end else if (h1Vld) begin
          grantValid = 1'b1;
          grantHost  = HOST1;
        end
      end
    endcase
  end

  // Full FIFO blocks requests regardless of a same-cycle pop, so there is
  // no combinational path from the response channel into the request side.
  assign gstVld    = grantValid & ~fifoFull;
  assign reqAccept = gstVld & gst_bti_req_mst.rdy;
  assign selAddr   = (grantHost == HOST1) ? h1_bti_req_slv.addr  : h0_bti_req_slv.addr;
  assign selWdata  = (grantHost == HOST1) ? h1_bti_req_slv.wdata : h0_bti_req_slv.wdata;

  assign gst_bti_req_mst.vld   = gstVld;
  assign gst_bti_req_mst.cmd   = (grantHost == HOST1) ? h1_bti_req_slv.cmd : h0_bti_req_slv.cmd;
  assign gst_bti_req_mst.addr  = selAddr;
  assign gst_bti_req_mst.wdata = selWdata;

  assign h0_bti_req_slv.rdy = gstVld & (grantHost == HOST0) & gst_bti_req_mst.rdy;
  assign h1_bti_req_slv.rdy = gstVld & (grantHost == HOST1) & gst_bti_req_mst.rdy;

  bti_ost_fifo #(
    .DEPTH (OST_NUM)
  ) u_ost_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (reqAccept),
    .data_i  (grantHost),
    .pop_i   (rspFire),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (headHost)
  );

  // During reset the FIFO is treated as empty so responses are swallowed
  // and no host sees a response.
  assign trackEmpty = fifoEmpty | ~rst_n;

  // Responses with no owner are accepted and dropped; otherwise the head
  // host's backpressure is returned to the guest.
  assign gstRspRdy = trackEmpty ? 1'b1
                   : ((headHost == HOST1) ? h1_bti_rsp_mst.rdy : h0_bti_rsp_mst.rdy);
  assign gst_bti_rsp_slv.rdy = gstRspRdy;

  assign rspFire = gst_bti_rsp_slv.vld & gstRspRdy & ~trackEmpty;
  assign orphan  = rst_n & gst_bti_rsp_slv.vld & fifoEmpty;

  assign h0_bti_rsp_mst.vld   = gst_bti_rsp_slv.vld & ~trackEmpty & (headHost == HOST0);
  assign h1_bti_rsp_mst.vld   = gst_bti_rsp_slv.vld & ~trackEmpty & (headHost == HOST1);
  assign h0_bti_rsp_mst.rdata = gst_bti_rsp_slv.rdata;
  assign h1_bti_rsp_mst.rdata = gst_bti_rsp_slv.rdata;
  assign h0_bti_rsp_mst.ok    = gst_bti_rsp_slv.ok;
  assign h1_bti_rsp_mst.ok    = gst_bti_rsp_slv.ok;

  assign err = errFlag_q & rst_n;

endmodule

// File: tb/tb_bti_arb.sv
// ---------------------------------------------------------------------------
// tb_bti_arb
// Directed bench for bti_arb. A queue-based model of the arbiter runs beside
// the DUT and is compared every cycle; literal checks in the stimulus pin
// the expected grant order, backpressure, routing and error behaviour.
// ---------------------------------------------------------------------------
module tb_bti_arb;
  import bti_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int OST = 2;

  typedef struct {
    logic          rstN;
    logic          h0Vld;
    logic          h1Vld;
    bti_cmd_e      h0Cmd;
    bti_cmd_e      h1Cmd;
    logic [AW-1:0] h0Addr;
    logic [AW-1:0] h1Addr;
    logic [DW-1:0] h0Wdata;
    logic [DW-1:0] h1Wdata;
    logic          gstRdy;
    logic          rspVld;
    logic [DW-1:0] rspData;
    logic          rspOk;
    logic          h0RspRdy;
    logic          h1RspRdy;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  err;
  stim_t cur;
  int    checks = 0;
  int    fails  = 0;

  // Model state
  int       mq[$];
  int       lastWinner;
  int       lockHost;
  int       winner;
  bit       errM;
  bit       room;
  bit       expGstVld;
  bit       expRdy0, expRdy1;
  bit       expRspVld0, expRspVld1;
  bit       expGstRspRdy;
  bit       expErr;
  int       head;

  always #5 clk = ~clk;

  bti_req_if_t #(.AW(AW), .DW(DW)) h0Req ();
  bti_req_if_t #(.AW(AW), .DW(DW)) h1Req ();
  bti_req_if_t #(.AW(AW), .DW(DW)) gstReq ();
  bti_rsp_if_t #(.DW(DW)) h0Rsp ();
  bti_rsp_if_t #(.DW(DW)) h1Rsp ();
  bti_rsp_if_t #(.DW(DW)) gstRsp ();

  bti_arb #(
    .BTI_AW  (AW),
    .BTI_DW  (DW),
    .OST_NUM (OST)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .h0_bti_req_slv  (h0Req),
    .h0_bti_rsp_mst  (h0Rsp),
    .h1_bti_req_slv  (h1Req),
    .h1_bti_rsp_mst  (h1Rsp),
    .gst_bti_req_mst (gstReq),
    .gst_bti_rsp_slv (gstRsp),
    .err             (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInputs(input stim_t s);
    rst_n        = s.rstN;
    h0Req.vld    = s.h0Vld;
    h0Req.cmd    = s.h0Cmd;
    h0Req.addr   = s.h0Addr;
    h0Req.wdata  = s.h0Wdata;
    h1Req.vld    = s.h1Vld;
    h1Req.cmd    = s.h1Cmd;
    h1Req.addr   = s.h1Addr;
    h1Req.wdata  = s.h1Wdata;
    gstReq.rdy   = s.gstRdy;
    gstRsp.vld   = s.rspVld;
    gstRsp.rdata = s.rspData;
    gstRsp.ok    = s.rspOk;
    h0Rsp.rdy    = s.h0RspRdy;
    h1Rsp.rdy    = s.h1RspRdy;
  endtask

  // Inputs change just after the rising edge, outputs are checked on the
  // falling edge of the same cycle.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    driveInputs(s);
    @(negedge clk);
  endtask

  // Reference model: arbitration from the round-robin and lock rules, an
  // ordered queue of owning hosts, and a sticky orphan flag.
  initial begin
    mq.delete();
    lastWinner = 1;
    lockHost   = -1;
    errM       = 1'b0;
    forever begin
      @(negedge clk);
      winner = -1;
      if (rst_n === 1'b1) begin
        if (lockHost >= 0) begin
          if ((lockHost == 0 && h0Req.vld) || (lockHost == 1 && h1Req.vld)) winner = lockHost;
        end else if (h0Req.vld && h1Req.vld) begin
          winner = (lastWinner == 0) ? 1 : 0;
        end else if (h0Req.vld) begin
          winner = 0;
        end else if (h1Req.vld) begin
          winner = 1;
        end
      end
      room       = (mq.size() < OST);
      expGstVld  = (winner >= 0) && room;
      expRdy0    = (winner == 0) && room && gstReq.rdy;
      expRdy1    = (winner == 1) && room && gstReq.rdy;
      expRspVld0 = 1'b0;
      expRspVld1 = 1'b0;
      expGstRspRdy = 1'b1;
      head = -1;
      if (rst_n === 1'b1 && mq.size() > 0) begin
        head = mq[0];
        expRspVld0   = gstRsp.vld && (head == 0);
        expRspVld1   = gstRsp.vld && (head == 1);
        expGstRspRdy = (head == 0) ? h0Rsp.rdy : h1Rsp.rdy;
      end
      expErr = (rst_n === 1'b1) ? errM : 1'b0;

      checkOutput("h0_rdy", {31'd0, h0Req.rdy}, {31'd0, expRdy0});
      checkOutput("h1_rdy", {31'd0, h1Req.rdy}, {31'd0, expRdy1});
      checkOutput("gst_vld", {31'd0, gstReq.vld}, {31'd0, expGstVld});
      checkOutput("h0_rsp_vld", {31'd0, h0Rsp.vld}, {31'd0, expRspVld0});
      checkOutput("h1_rsp_vld", {31'd0, h1Rsp.vld}, {31'd0, expRspVld1});
      checkOutput("gst_rsp_rdy", {31'd0, gstRsp.rdy}, {31'd0, expGstRspRdy});
      checkOutput("err", {31'd0, err}, {31'd0, expErr});
      if (expGstVld) begin
        checkOutput("gst_addr", gstReq.addr, (winner == 1) ? h1Req.addr : h0Req.addr);
        checkOutput("gst_wdata", gstReq.wdata, (winner == 1) ? h1Req.wdata : h0Req.wdata);
        checkOutput("gst_cmd", {31'd0, gstReq.cmd}, {31'd0, (winner == 1) ? h1Req.cmd : h0Req.cmd});
      end
      if (expRspVld0) begin
        checkOutput("h0_rdata", h0Rsp.rdata, gstRsp.rdata);
        checkOutput("h0_ok", {31'd0, h0Rsp.ok}, {31'd0, gstRsp.ok});
      end
      if (expRspVld1) begin
        checkOutput("h1_rdata", h1Rsp.rdata, gstRsp.rdata);
        checkOutput("h1_ok", {31'd0, h1Rsp.ok}, {31'd0, gstRsp.ok});
      end

      @(posedge clk);
      if (rst_n !== 1'b1) begin
        mq.delete();
        lastWinner = 1;
        lockHost   = -1;
        errM       = 1'b0;
      end else begin
        if (gstRsp.vld && expGstRspRdy) begin
          if (mq.size() == 0) errM = 1'b1;
          else void'(mq.pop_front());
        end
        if (expGstVld && gstReq.rdy) begin
          mq.push_back(winner);
          lastWinner = winner;
          lockHost   = -1;
        end else begin
          lockHost = winner;
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    cur = '{rstN: 1'b0, h0Vld: 1'b1, h1Vld: 1'b1, h0Cmd: BTI_READ, h1Cmd: BTI_READ,
            h0Addr: 32'h0000_0100, h1Addr: 32'h0000_0200,
            h0Wdata: 32'h0000_0A0A, h1Wdata: 32'h0000_0B0B,
            gstRdy: 1'b1, rspVld: 1'b0, rspData: 32'h0, rspOk: 1'b1,
            h0RspRdy: 1'b1, h1RspRdy: 1'b1};
    driveInputs(cur);

    // Reset holds every handshake low even with requests pending.
    applyStimulus(cur);
    checkOutput("rst_h0_rdy", {31'd0, h0Req.rdy}, 32'd0);
    checkOutput("rst_gst_vld", {31'd0, gstReq.vld}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    applyStimulus(cur);

    // Both hosts READ from reset with guest always ready: h0, h1, h0, ...
    cur.rstN = 1'b1;
    applyStimulus(cur);
    checkOutput("rr0_h0_rdy", {31'd0, h0Req.rdy}, 32'd1);
    checkOutput("rr0_h1_rdy", {31'd0, h1Req.rdy}, 32'd0);
    checkOutput("rr0_addr", gstReq.addr, 32'h0000_0100);
    for (int i = 1; i <= 5; i++) begin
      cur.rspVld  = 1'b1;
      cur.rspData = 32'hA000_0000 + i;
      applyStimulus(cur);
      checkOutput("rr_h0_rdy", {31'd0, h0Req.rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("rr_h1_rdy", {31'd0, h1Req.rdy}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 1) checkOutput("rr1_h0_rsp_vld", {31'd0, h0Rsp.vld}, 32'd1);
    end
    cur.h0Vld = 1'b0;
    cur.h1Vld = 1'b0;
    applyStimulus(cur);
    checkOutput("drain_h1_rsp_vld", {31'd0, h1Rsp.vld}, 32'd1);
    cur.rspVld = 1'b0;
    applyStimulus(cur);

    // h1 WRITE held by guest backpressure for 3 cycles while h0 joins.
    cur.h1Vld   = 1'b1;
    cur.h1Cmd   = BTI_WRITE;
    cur.h1Addr  = 32'h1000_0004;
    cur.h1Wdata = 32'hCAFE_0001;
    cur.gstRdy  = 1'b0;
    applyStimulus(cur);
    checkOutput("lock0_addr", gstReq.addr, 32'h1000_0004);
    cur.h0Vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(cur);
      checkOutput("lock_addr", gstReq.addr, 32'h1000_0004);
      checkOutput("lock_cmd", {31'd0, gstReq.cmd}, 32'd1);
      checkOutput("lock_h0_rdy", {31'd0, h0Req.rdy}, 32'd0);
    end
    cur.gstRdy = 1'b1;
    applyStimulus(cur);
    checkOutput("lock_rel_h1_rdy", {31'd0, h1Req.rdy}, 32'd1);
    checkOutput("lock_rel_h0_rdy", {31'd0, h0Req.rdy}, 32'd0);
    cur.h1Vld = 1'b0;
    applyStimulus(cur);
    checkOutput("after_lock_h0_rdy", {31'd0, h0Req.rdy}, 32'd1);
    checkOutput("after_lock_addr", gstReq.addr, 32'h0000_0100);

    // Two outstanding, no responses: a third request is blocked, including
    // on the cycle the first response pops.
    cur.h0Addr = 32'h0000_0104;
    applyStimulus(cur);
    checkOutput("full_h0_rdy", {31'd0, h0Req.rdy}, 32'd0);
    checkOutput("full_gst_vld", {31'd0, gstReq.vld}, 32'd0);
    applyStimulus(cur);
    cur.rspVld  = 1'b1;
    cur.rspData = 32'h1111_1111;
    applyStimulus(cur);
    checkOutput("full_pop_h0_rdy", {31'd0, h0Req.rdy}, 32'd0);
    checkOutput("full_pop_h1_rsp_vld", {31'd0, h1Rsp.vld}, 32'd1);
    cur.rspVld = 1'b0;
    applyStimulus(cur);
    checkOutput("unfull_h0_rdy", {31'd0, h0Req.rdy}, 32'd1);
    cur.h0Vld  = 1'b0;
    cur.rspVld = 1'b1;
    applyStimulus(cur);
    applyStimulus(cur);
    cur.rspVld = 1'b0;
    applyStimulus(cur);

    // Accepted order h0 then h1; responses route back in that order.
    cur.h0Vld  = 1'b1;
    cur.h0Addr = 32'h0000_0200;
    applyStimulus(cur);
    checkOutput("ord_h0_rdy", {31'd0, h0Req.rdy}, 32'd1);
    cur.h0Vld  = 1'b0;
    cur.h1Vld  = 1'b1;
    cur.h1Cmd  = BTI_READ;
    cur.h1Addr = 32'h0000_0300;
    applyStimulus(cur);
    checkOutput("ord_h1_rdy", {31'd0, h1Req.rdy}, 32'd1);
    cur.h1Vld    = 1'b0;
    cur.rspVld   = 1'b1;
    cur.rspData  = 32'hDEAD_BEEF;
    cur.h0RspRdy = 1'b0;
    applyStimulus(cur);
    checkOutput("bp_gst_rsp_rdy", {31'd0, gstRsp.rdy}, 32'd0);
    cur.h0RspRdy = 1'b1;
    applyStimulus(cur);
    checkOutput("rsp0_h0_vld", {31'd0, h0Rsp.vld}, 32'd1);
    checkOutput("rsp0_h0_rdata", h0Rsp.rdata, 32'hDEAD_BEEF);
    checkOutput("rsp0_h1_vld", {31'd0, h1Rsp.vld}, 32'd0);
    cur.rspData = 32'h1234_5678;
    applyStimulus(cur);
    checkOutput("rsp1_h1_vld", {31'd0, h1Rsp.vld}, 32'd1);
    checkOutput("rsp1_h1_rdata", h1Rsp.rdata, 32'h1234_5678);
    checkOutput("rsp1_h0_vld", {31'd0, h0Rsp.vld}, 32'd0);

    // Orphan response: accepted, dropped, err becomes sticky.
    cur.rspData = 32'h5555_5555;
    applyStimulus(cur);
    checkOutput("orph_gst_rsp_rdy", {31'd0, gstRsp.rdy}, 32'd1);
    checkOutput("orph_h0_vld", {31'd0, h0Rsp.vld}, 32'd0);
    checkOutput("orph_h1_vld", {31'd0, h1Rsp.vld}, 32'd0);
    cur.rspVld = 1'b0;
    applyStimulus(cur);
    checkOutput("orph_err", {31'd0, err}, 32'd1);
    applyStimulus(cur);
    checkOutput("orph_err_sticky", {31'd0, err}, 32'd1);

    // Reset with two outstanding; a late response is then an orphan.
    cur.h0Vld = 1'b1;
    applyStimulus(cur);
    cur.h0Vld = 1'b0;
    cur.h1Vld = 1'b1;
    applyStimulus(cur);
    cur.rstN  = 1'b0;
    cur.h0Vld = 1'b1;
    applyStimulus(cur);
    checkOutput("mrst_err", {31'd0, err}, 32'd0);
    checkOutput("mrst_gst_vld", {31'd0, gstReq.vld}, 32'd0);
    checkOutput("mrst_h1_rdy", {31'd0, h1Req.rdy}, 32'd0);
    cur.rstN    = 1'b1;
    cur.h0Vld   = 1'b0;
    cur.h1Vld   = 1'b0;
    cur.rspVld  = 1'b1;
    cur.rspData = 32'h7777_7777;
    applyStimulus(cur);
    checkOutput("late_h0_vld", {31'd0, h0Rsp.vld}, 32'd0);
    checkOutput("late_h1_vld", {31'd0, h1Rsp.vld}, 32'd0);
    checkOutput("late_gst_rsp_rdy", {31'd0, gstRsp.rdy}, 32'd1);
    cur.rspVld = 1'b0;
    applyStimulus(cur);
    checkOutput("late_err", {31'd0, err}, 32'd1);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
